screen_ctrl: RTL

Top-level screen sequencer for the game. Owns the game-phase state machine (START → PLAY → FINISH → START), debounces the player's start button and takes the game-over event from game logic. It selects which of three frame-aligned VGA streams reaches the display: start screen, game renderer or finish screen. Screen changes happen only at a frame boundary, so the display never tears mid-frame.

---
 rtl/screen_pkg.sv | 23 ++
 rtl/vga_if.sv | 13 +
 rtl/btn_debounce.sv | 42 ++++
 rtl/screen_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/screen_pkg.sv
// Shared types and default parameters for the screen sequencer.
package screen_pkg;

  typedef enum logic [1:0] {
    SCR_START  = 2'd0,
    SCR_PLAY   = 2'd1,
    SCR_FINISH = 2'd2
  } screen_t;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  localparam int DEF_DEBOUNCE_CYCLES = 650_000;
  localparam int DEF_FINISH_FRAMES   = 600;

endpackage

// File: rtl/vga_if.sv
// Frame-aligned VGA stream: timing counters, sync/blank flags and pixel colour.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/btn_debounce.sv
// Accepts a new button level after DEBOUNCE_CYCLES stable samples; rise pulses
// for one cycle on an accepted 0->1 change, DEBOUNCE_CYCLES+1 cycles after the edge.
module btn_debounce
  import screen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          din_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      din_q <= 1'b0;
      cnt   <= '0;
      dout  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      din_q <= din;
      rise  <= 1'b0;
      // Any change restarts the stability run; the count saturates once stable.
      if (din != din_q) begin
        cnt <= '0;
      end else if (cnt != CNT_LAST) begin
        cnt <= cnt + 1'b1;
      end else if (din_q != dout) begin
        dout <= din_q;
        rise <= din_q;
      end
    end
  end

endmodule

// File: rtl/screen_ctrl.sv
// Game-phase sequencer: START -> PLAY -> FINISH -> START, with screen changes
// deferred to the next vblnk rise and the chosen VGA stream registered once.
module screen_ctrl
  import screen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int FINISH_FRAMES   = DEF_FINISH_FRAMES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       game_over,
  vga_if.in          vga_start,
  vga_if.in          vga_game,
  vga_if.in          vga_finish,
  vga_if.out         vga_out,
  output logic [1:0] screen,
  output logic       game_en,
  output logic       new_game
);

  localparam int FW = (FINISH_FRAMES > 1) ? $clog2(FINISH_FRAMES) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(FINISH_FRAMES - 1);

  logic          btn_level;
  logic          btn_rise;
  logic          press;
  logic          vblnk_q;
  logic          tick;
  screen_t       phase;
  screen_t       pend;
  logic          pend_vld;
  logic [FW-1:0] fcnt;
  logic [FW-1:0] fcnt_nxt;
  vga_t          sel;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .din  (btn_start),
    .dout (btn_level),
    .rise (btn_rise)
  );

  assign press    = btn_rise & btn_level;
  assign tick     = vga_start.vblnk & ~vblnk_q;
  assign fcnt_nxt = (fcnt == F_LAST) ? fcnt : fcnt + 1'b1;
  assign screen   = phase;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblnk_q  <= 1'b0;
      phase    <= SCR_START;
      pend     <= SCR_START;
      pend_vld <= 1'b0;
      fcnt     <= '0;
      game_en  <= 1'b0;
      new_game <= 1'b0;
    end else begin
      vblnk_q  <= vga_start.vblnk;
      new_game <= 1'b0;
      if (tick && pend_vld) begin
        phase    <= pend;
        pend_vld <= 1'b0;
        fcnt     <= '0;
        new_game <= (pend == SCR_PLAY);
        game_en  <= (pend == SCR_PLAY);
      end else begin
        if (tick && phase == SCR_FINISH) fcnt <= fcnt_nxt;
        // Only one request may be outstanding; later events are dropped.
        if (!pend_vld) begin
          unique case (phase)
            SCR_START: if (press) begin
              pend     <= SCR_PLAY;
              pend_vld <= 1'b1;
            end
            SCR_PLAY: if (game_over) begin
              pend     <= SCR_FINISH;
              pend_vld <= 1'b1;
            end
            SCR_FINISH: if (press || (tick && fcnt_nxt == F_LAST)) begin
              pend     <= SCR_START;
              pend_vld <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    sel = '0;
    unique case (phase)
      SCR_PLAY:   sel = {vga_game.hcount, vga_game.vcount, vga_game.hsync,
                         vga_game.vsync, vga_game.hblnk, vga_game.vblnk, vga_game.rgb};
      SCR_FINISH: sel = {vga_finish.hcount, vga_finish.vcount, vga_finish.hsync,
                         vga_finish.vsync, vga_finish.hblnk, vga_finish.vblnk, vga_finish.rgb};
      default:    sel = {vga_start.hcount, vga_start.vcount, vga_start.hsync,
                         vga_start.vsync, vga_start.hblnk, vga_start.vblnk, vga_start.rgb};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_out.hcount <= '0;
      vga_out.vcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.hcount <= sel.hcount;
      vga_out.vcount <= sel.vcount;
      vga_out.hsync  <= sel.hsync;
      vga_out.vsync  <= sel.vsync;
      vga_out.hblnk  <= sel.hblnk;
      vga_out.vblnk  <= sel.vblnk;
      vga_out.rgb    <= sel.rgb;
    end
  end

endmodule
